// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: issues a run of phase increments to the DDS,
// one handshake per value, holding each value for a programmed dwell time.
module dds_sweep_ctrl #(
  parameter int PINC_W  = 32,
  parameter int DWELL_W = 24,
  parameter int STEPS_W = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [PINC_W-1:0]  cfg_start_pinc,
  input  logic [PINC_W-1:0]  cfg_step_pinc,
  input  logic [STEPS_W-1:0] cfg_num_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_continuous,
  input  logic               start,
  input  logic               abort,
  output logic [PINC_W-1:0]  pinc_out,
  output logic               pinc_valid,
  input  logic               pinc_ready,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] step_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [PINC_W-1:0]  start_pinc_q;
  logic [PINC_W-1:0]  step_pinc_q;
  logic [STEPS_W-1:0] last_idx_q;
  logic [DWELL_W-1:0] dwell_load_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               continuous_q;
  logic               abort_pending;

  logic do_start;
  logic do_accept;
  logic do_advance;
  logic do_wrap;
  logic last_step;

  // Outputs decode straight from the state register, so they cannot glitch.
  assign pinc_valid = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign last_step  = (step_idx == last_idx_q);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_accept  = 1'b0;
    do_advance = 1'b0;
    do_wrap    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          do_start   = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An abort seen while waiting only takes effect once the DDS accepts.
        if (pinc_ready) begin
          if (abort || abort_pending) begin
            state_next = S_IDLE;
          end else begin
            do_accept  = 1'b1;
            state_next = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (dwell_cnt == '0) begin
          if (!last_step) begin
            do_advance = 1'b1;
            state_next = S_ISSUE;
          end else if (continuous_q) begin
            do_wrap    = 1'b1;
            state_next = S_ISSUE;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Shadow registers hold the sweep parameters so the register block may be
  // rewritten mid-sweep; zero step count and zero dwell both behave as one.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_pinc_q  <= '0;
      step_pinc_q   <= '0;
      last_idx_q    <= '0;
      dwell_load_q  <= '0;
      continuous_q  <= 1'b0;
      pinc_out      <= '0;
      step_idx      <= '0;
      dwell_cnt     <= '0;
      abort_pending <= 1'b0;
    end else begin
      if (do_start) begin
        start_pinc_q <= cfg_start_pinc;
        step_pinc_q  <= cfg_step_pinc;
        last_idx_q   <= (cfg_num_steps == '0) ? '0 : cfg_num_steps - STEPS_W'(1);
        dwell_load_q <= (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
        continuous_q <= cfg_continuous;
        pinc_out     <= cfg_start_pinc;
        step_idx     <= '0;
      end else if (do_wrap) begin
        pinc_out <= start_pinc_q;
        step_idx <= '0;
      end else if (do_advance) begin
        pinc_out <= pinc_out + step_pinc_q;
        step_idx <= step_idx + STEPS_W'(1);
      end

      if (do_accept) begin
        dwell_cnt <= dwell_load_q;
      end else if ((state == S_DWELL) && (dwell_cnt != '0)) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end

      abort_pending <= (state == S_ISSUE) && !pinc_ready && (abort || abort_pending);
    end
  end

endmodule
